// File: rtl/reg_writeback_pkg.sv
// rtl/reg_writeback_pkg.sv - shared defaults and grant-select encoding for the writeback unit
package reg_writeback_pkg;

  localparam int WB_WIDTH        = 16;
  localparam int WB_REG_BITS     = 4;
  localparam int WB_STARVE_LIMIT = 3;

  typedef enum logic [1:0] {
    GRANT_NONE = 2'd0,
    GRANT_ALU  = 2'd1,
    GRANT_LD   = 2'd2
  } grant_e;

endpackage

// File: rtl/wb_scoreboard.sv
// rtl/wb_scoreboard.sv - pending-write scoreboard with hazard and bypass lookup
// Optional same-cycle forwarding of the output-stage write under WB_BYPASS_EN.
module wb_scoreboard
  import reg_writeback_pkg::*;
#(
  parameter int REG_BITS = WB_REG_BITS
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   set_valid_i,
  input  logic [REG_BITS-1:0]    set_index_i,
  output logic                   set_ready_o,
  input  logic                   clr_valid_i,
  input  logic [REG_BITS-1:0]    clr_index_i,
  input  logic [REG_BITS-1:0]    chk_index_a_i,
  input  logic [REG_BITS-1:0]    chk_index_b_i,
  output logic                   hazard_a_o,
  output logic                   hazard_b_o,
  output logic                   fwd_valid_a_o,
  output logic                   fwd_valid_b_o,
  output logic [2**REG_BITS-1:0] busy_o
);

  logic [2**REG_BITS-1:0] busy_q, busy_d;

  // Register 0 is hardwired and never reserved, so it is always accepted.
  assign set_ready_o = (set_index_i == '0) || !busy_q[set_index_i];

  always_comb begin
    busy_d = busy_q;
    if (clr_valid_i) busy_d[clr_index_i] = 1'b0;
    if (set_valid_i && set_ready_o && (set_index_i != '0)) busy_d[set_index_i] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

`ifdef WB_BYPASS_EN
  assign fwd_valid_a_o = clr_valid_i && (clr_index_i == chk_index_a_i) && (chk_index_a_i != '0);
  assign fwd_valid_b_o = clr_valid_i && (clr_index_i == chk_index_b_i) && (chk_index_b_i != '0);
`else
  assign fwd_valid_a_o = 1'b0;
  assign fwd_valid_b_o = 1'b0;
`endif

  assign hazard_a_o = (chk_index_a_i != '0) && busy_q[chk_index_a_i] && !fwd_valid_a_o;
  assign hazard_b_o = (chk_index_b_i != '0) && busy_q[chk_index_b_i] && !fwd_valid_b_o;
  assign busy_o     = busy_q;

endmodule

// File: rtl/reg_writeback.sv
// rtl/reg_writeback.sv - ALU/load result arbiter, registered write port and scoreboard
// WB_BYPASS_EN enables forwarding of the in-flight write to the operand checks.
module reg_writeback
  import reg_writeback_pkg::*;
#(
  parameter int WIDTH        = WB_WIDTH,
  parameter int REG_BITS     = WB_REG_BITS,
  parameter int STARVE_LIMIT = WB_STARVE_LIMIT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   issue_valid,
  input  logic [REG_BITS-1:0]    issue_index,
  output logic                   issue_ready,
  input  logic                   alu_valid,
  output logic                   alu_ready,
  input  logic [REG_BITS-1:0]    alu_index,
  input  logic [WIDTH-1:0]       alu_data,
  input  logic                   ld_valid,
  output logic                   ld_ready,
  input  logic [REG_BITS-1:0]    ld_index,
  input  logic [WIDTH-1:0]       ld_data,
  output logic                   reg_write,
  output logic [REG_BITS-1:0]    wr_index,
  output logic [WIDTH-1:0]       write_data,
  output logic [2**REG_BITS-1:0] busy,
  input  logic [REG_BITS-1:0]    chk_index_a,
  input  logic [REG_BITS-1:0]    chk_index_b,
  output logic                   hazard_a,
  output logic                   hazard_b,
  output logic                   fwd_valid_a,
  output logic                   fwd_valid_b,
  output logic [WIDTH-1:0]       fwd_data_a,
  output logic [WIDTH-1:0]       fwd_data_b,
  output logic                   err_unreserved
);

  localparam logic [1:0] LIMIT = 2'(STARVE_LIMIT);

  grant_e                grant;
  logic                  contest, alu_wins;
  logic [1:0]            streak_q, streak_d;
  logic                  reg_write_q, reg_write_d;
  logic [REG_BITS-1:0]   wr_index_q, wr_index_d, sel_index;
  logic [WIDTH-1:0]      write_data_q, write_data_d, sel_data;
  logic                  err_q, err_d;

  assign contest  = alu_valid && ld_valid;
  assign alu_wins = (streak_q == LIMIT);

  // Each ready only looks at the other source, so a source never waits on itself.
  assign alu_ready = !ld_valid || alu_wins;
  assign ld_ready  = !alu_valid || !alu_wins;

  always_comb begin
    grant = GRANT_NONE;
    if (contest)        grant = alu_wins ? GRANT_ALU : GRANT_LD;
    else if (alu_valid) grant = GRANT_ALU;
    else if (ld_valid)  grant = GRANT_LD;
  end

  assign sel_index = (grant == GRANT_LD) ? ld_index : alu_index;
  assign sel_data  = (grant == GRANT_LD) ? ld_data  : alu_data;

  always_comb begin
    streak_d     = streak_q;
    reg_write_d  = 1'b0;
    wr_index_d   = wr_index_q;
    write_data_d = write_data_q;
    err_d        = err_q;
    if (grant == GRANT_ALU) streak_d = '0;
    else if ((grant == GRANT_LD) && contest && (streak_q != LIMIT)) streak_d = streak_q + 2'd1;
    if (grant != GRANT_NONE) begin
      reg_write_d  = (sel_index != '0);
      wr_index_d   = sel_index;
      write_data_d = sel_data;
      if ((sel_index != '0) && !busy[sel_index]) err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      streak_q     <= '0;
      reg_write_q  <= 1'b0;
      wr_index_q   <= '0;
      write_data_q <= '0;
      err_q        <= 1'b0;
    end else begin
      streak_q     <= streak_d;
      reg_write_q  <= reg_write_d;
      wr_index_q   <= wr_index_d;
      write_data_q <= write_data_d;
      err_q        <= err_d;
    end
  end

  wb_scoreboard #(.REG_BITS(REG_BITS)) u_scoreboard (
    .clk           (clk),
    .rst_n         (rst_n),
    .set_valid_i   (issue_valid),
    .set_index_i   (issue_index),
    .set_ready_o   (issue_ready),
    .clr_valid_i   (reg_write_q),
    .clr_index_i   (wr_index_q),
    .chk_index_a_i (chk_index_a),
    .chk_index_b_i (chk_index_b),
    .hazard_a_o    (hazard_a),
    .hazard_b_o    (hazard_b),
    .fwd_valid_a_o (fwd_valid_a),
    .fwd_valid_b_o (fwd_valid_b),
    .busy_o        (busy)
  );

`ifdef WB_BYPASS_EN
  assign fwd_data_a = write_data_q;
  assign fwd_data_b = write_data_q;
`else
  assign fwd_data_a = '0;
  assign fwd_data_b = '0;
`endif

  assign reg_write      = reg_write_q;
  assign wr_index       = wr_index_q;
  assign write_data     = write_data_q;
  assign err_unreserved = err_q;

endmodule

// File: tb/tb_reg_writeback.sv
// tb/tb_reg_writeback.sv - directed bench with write scoreboard; honours WB_BYPASS_EN
module tb_reg_writeback;

`ifdef WB_BYPASS_EN
  localparam bit BYPASS_ON = 1'b1;
`else
  localparam bit BYPASS_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        issue_valid, issue_ready;
  logic [3:0]  issue_index;
  logic        alu_valid, alu_ready, ld_valid, ld_ready;
  logic [3:0]  alu_index, ld_index;
  logic [15:0] alu_data, ld_data;
  logic        reg_write;
  logic [3:0]  wr_index;
  logic [15:0] write_data;
  logic [15:0] busy;
  logic [3:0]  chk_index_a, chk_index_b;
  logic        hazard_a, hazard_b, fwd_valid_a, fwd_valid_b;
  logic [15:0] fwd_data_a, fwd_data_b;
  logic        err_unreserved;

  always #5 clk = ~clk;

  reg_writeback dut (
    .clk(clk), .rst_n(rst_n),
    .issue_valid(issue_valid), .issue_index(issue_index), .issue_ready(issue_ready),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_index(alu_index), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_index(ld_index), .ld_data(ld_data),
    .reg_write(reg_write), .wr_index(wr_index), .write_data(write_data), .busy(busy),
    .chk_index_a(chk_index_a), .chk_index_b(chk_index_b),
    .hazard_a(hazard_a), .hazard_b(hazard_b),
    .fwd_valid_a(fwd_valid_a), .fwd_valid_b(fwd_valid_b),
    .fwd_data_a(fwd_data_a), .fwd_data_b(fwd_data_b),
    .err_unreserved(err_unreserved)
  );

  typedef struct packed {
    logic        rw;
    logic [3:0]  idx;
    logic [15:0] data;
  } wr_t;

  int          n_vec = 0;
  int          n_bad = 0;
  int          n_writes = 0;
  int          last_g = 0;
  int          streak_m = 0;
  wr_t         exp_q[$];
  wr_t         out_m;
  logic [15:0] busy_m;
  logic        err_m;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic byp(input logic [3:0] c);
    return BYPASS_ON && out_m.rw && (out_m.idx == c) && (c != 4'd0);
  endfunction

  task automatic check_state();
    chk("busy", busy, busy_m);
    chk("err_unreserved", err_unreserved, err_m);
    chk("hazard_a", hazard_a, (chk_index_a != 4'd0) && busy_m[chk_index_a] && !byp(chk_index_a));
    chk("hazard_b", hazard_b, (chk_index_b != 4'd0) && busy_m[chk_index_b] && !byp(chk_index_b));
    chk("fwd_valid_a", fwd_valid_a, byp(chk_index_a));
    chk("fwd_valid_b", fwd_valid_b, byp(chk_index_b));
    chk("fwd_data_a", fwd_data_a, BYPASS_ON ? out_m.data : 16'h0);
  endtask

  // One clock: predict grant/readies, push the expected output stage, then pop and compare.
  task automatic tick();
    logic        hs;
    logic [3:0]  gi;
    logic [15:0] gd, nb;
    wr_t         e;
    #1;
    if (alu_valid && ld_valid) last_g = (streak_m == 3) ? 1 : 2;
    else if (alu_valid)        last_g = 1;
    else if (ld_valid)         last_g = 2;
    else                       last_g = 0;
    if (alu_valid) chk("alu_ready", alu_ready, last_g == 1);
    if (ld_valid)  chk("ld_ready", ld_ready, last_g == 2);
    hs = issue_valid && ((issue_index == 4'd0) || !busy_m[issue_index]);
    if (issue_valid) chk("issue_ready", issue_ready, hs);
    nb = busy_m;
    if (out_m.rw) nb[out_m.idx] = 1'b0;
    if (hs && issue_index != 4'd0) nb[issue_index] = 1'b1;
    if (last_g != 0) begin
      gi = (last_g == 1) ? alu_index : ld_index;
      gd = (last_g == 1) ? alu_data : ld_data;
      if (gi != 4'd0 && !busy_m[gi]) err_m = 1'b1;
      exp_q.push_back('{rw: (gi != 4'd0), idx: gi, data: gd});
      if (last_g == 1) streak_m = 0;
      else if (alu_valid && streak_m < 3) streak_m++;
    end else begin
      exp_q.push_back('{rw: 1'b0, idx: out_m.idx, data: out_m.data});
    end
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    out_m  = e;
    busy_m = nb;
    if (reg_write === 1'b1) n_writes++;
    chk("reg_write", reg_write, e.rw);
    chk("wr_index", wr_index, e.idx);
    chk("write_data", write_data, e.data);
    check_state();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    busy_m   = '0;
    err_m    = 1'b0;
    streak_m = 0;
    out_m    = '0;
    exp_q.delete();
    chk("rst_reg_write", reg_write, 1'b0);
    chk("rst_wr_index", wr_index, 4'd0);
    chk("rst_write_data", write_data, 16'h0);
    check_state();
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int          pat[8] = '{2, 2, 2, 1, 2, 2, 2, 1};
    int          lq[$];
    int          aq[$];
    int          gseq[$];
    int          regs[8] = '{1, 2, 3, 4, 5, 6, 9, 10};
    logic [15:0] busy_save;

    rst_n = 1'b0;
    issue_valid = 1'b0; issue_index = 4'd0;
    alu_valid = 1'b1; alu_index = 4'd5; alu_data = 16'hBEEF;
    ld_valid  = 1'b1; ld_index  = 4'd6; ld_data  = 16'hCAFE;
    chk_index_a = 4'd0; chk_index_b = 4'd0;

    do_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hold_reg_write", reg_write, 1'b0);
    chk("rst_hold_busy", busy, 16'h0);
    alu_valid = 1'b0; ld_valid = 1'b0;
    release_reset();

    issue_valid = 1'b1; issue_index = 4'd5; chk_index_a = 4'd5;
    tick();
    chk("busy5_set", busy, 16'h0020);
    tick();
    issue_valid = 1'b0;
    alu_valid = 1'b1; alu_index = 4'd5; alu_data = 16'h1234;
    tick();
    chk("r5_wr_index", wr_index, 4'd5);
    chk("r5_write_data", write_data, 16'h1234);
    alu_valid = 1'b0;
    tick();
    chk("busy5_clear", busy, 16'h0);

    issue_valid = 1'b1; issue_index = 4'd2;
    tick();
    issue_valid = 1'b0;
    alu_valid = 1'b1; alu_index = 4'd2; alu_data = 16'h5555;
    tick();
    alu_valid = 1'b0;
    #2;
    do_reset();
    release_reset();
    tick();

    for (int i = 0; i < 8; i++) begin
      issue_valid = 1'b1; issue_index = 4'(regs[i]);
      tick();
    end
    issue_valid = 1'b0;
    lq = '{1, 2, 3, 4, 5, 6};
    aq = '{9, 10};
    n_writes = 0;
    for (int c = 0; c < 30 && (lq.size() > 0 || aq.size() > 0); c++) begin
      alu_valid = (aq.size() > 0);
      if (alu_valid) begin alu_index = 4'(aq[0]); alu_data = 16'hA000 | 16'(aq[0]); end
      ld_valid = (lq.size() > 0);
      if (ld_valid) begin ld_index = 4'(lq[0]); ld_data = 16'h1000 | 16'(lq[0]); end
      tick();
      gseq.push_back(last_g);
      if (last_g == 1) void'(aq.pop_front());
      if (last_g == 2) void'(lq.pop_front());
    end
    alu_valid = 1'b0; ld_valid = 1'b0;
    tick();
    chk("contest_grants", gseq.size(), 8);
    for (int i = 0; i < 8 && i < gseq.size(); i++) chk("grant_pattern", gseq[i], pat[i]);
    chk("contest_writes", n_writes, 8);
    tick();
    chk("contest_busy_empty", busy, 16'h0);

    busy_save = busy;
    alu_valid = 1'b1; alu_index = 4'd0; alu_data = 16'hFFFF;
    tick();
    chk("r0_no_write", reg_write, 1'b0);
    chk("r0_busy_same", busy, busy_save);
    alu_valid = 1'b0;

    alu_valid = 1'b1; alu_index = 4'd7; alu_data = 16'h7777;
    tick();
    chk("r7_written", reg_write, 1'b1);
    chk("r7_err", err_unreserved, 1'b1);
    alu_valid = 1'b0;
    tick();
    tick();
    chk("r7_err_sticky", err_unreserved, 1'b1);
    do_reset();
    release_reset();

    issue_valid = 1'b1; issue_index = 4'd3; chk_index_b = 4'd3;
    tick();
    tick();
    issue_valid = 1'b0;
    ld_valid = 1'b1; ld_index = 4'd3; ld_data = 16'h3333;
    tick();
    ld_valid = 1'b0;
`ifdef WB_BYPASS_EN
    chk("r3_fwd_valid_b", fwd_valid_b, 1'b1);
    chk("r3_fwd_data_b", fwd_data_b, 16'h3333);
    chk("r3_hazard_b", hazard_b, 1'b0);
`else
    chk("r3_fwd_valid_b", fwd_valid_b, 1'b0);
    chk("r3_fwd_data_b", fwd_data_b, 16'h0);
    chk("r3_hazard_b", hazard_b, 1'b1);
`endif
    tick();
    chk("r3_hazard_clear", hazard_b, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/reg_writeback.md
# reg_writeback

Writeback unit at the write side of the 16-bit register file. Accepts results from the ALU and the load unit over valid/ready handshakes, arbitrates them onto the single register-file write port (`reg_write`, write index, `write_data`), and keeps a per-register pending-write scoreboard so issue logic can stall on read-after-write hazards. One write per cycle, registered output stage, bounded-starvation arbitration.

## Interface
- `WIDTH`, 16, data width; matches register file
- `REG_BITS`, 4, register index width; 2^REG_BITS registers
- `STARVE_LIMIT`, 3, consecutive contested load grants before the ALU is forced through (1..3)
- `clk` in 1: sole clock, all state on rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `issue_valid` in 1: issue stage reserves destination `issue_index`
- `issue_index` in REG_BITS: destination being reserved
- `issue_ready` out 1: reservation accepted this cycle
- `alu_valid` / `alu_ready` in/out 1: ALU result handshake
- `alu_index` in REG_BITS, `alu_data` in WIDTH: ALU destination and value
- `ld_valid` / `ld_ready` in/out 1: load result handshake
- `ld_index` in REG_BITS, `ld_data` in WIDTH: load destination and value
- `reg_write` out 1: register-file write enable (registered)
- `wr_index` out REG_BITS: register-file write index (registered)
- `write_data` out WIDTH: register-file write data (registered)
- `busy` out 2^REG_BITS: scoreboard, bit i = write to register i pending
- `chk_index_a`, `chk_index_b` in REG_BITS: operand indices to check
- `hazard_a`, `hazard_b` out 1: combinational, operand register is busy
- `fwd_valid_a`, `fwd_valid_b` out 1; `fwd_data_a`, `fwd_data_b` out WIDTH: bypass (see Configuration)
- `err_unreserved` out 1: sticky, a result targeted a non-busy nonzero register

## Operation
- Reset: `reg_write`=0, `wr_index`=0, `write_data`=0, `busy`=0, streak counter=0, `err_unreserved`=0.
- `issue_ready` = `issue_index`==0 or !`busy[issue_index]`. Handshake (`issue_valid`&`issue_ready`) with `issue_index`≠0 sets `busy[issue_index]` at the edge. Index 0 never marked busy.
- Arbitration per cycle: only one valid → it is granted. Both valid (contest) → load granted unless streak counter == STARVE_LIMIT, then ALU granted. Loser's ready=0; a granted source's ready=1. Ready never depends on the source's own valid except via this rule.
- Streak counter: +1 on contested load grant; cleared on any ALU grant; holds otherwise. Saturates at STARVE_LIMIT.
- Granted result registered into output stage: `reg_write` = (index≠0), `wr_index`, `write_data` loaded. No grant → `reg_write`=0, index/data hold.
- Index 0 result: consumed (ready=1), never written, no scoreboard effect.
- Scoreboard clear: at the edge ending a cycle with `reg_write`=1, `busy[wr_index]` cleared (same edge the register file captures the data).
- Same-edge set and clear of one index cannot occur: `issue_ready` is 0 while busy.
- Granted result with nonzero index whose busy bit is 0 → written anyway, `err_unreserved` set until reset.
- `hazard_x` = `chk_index_x`≠0 and `busy[chk_index_x]`.

## Timing
- Grant at edge N → `reg_write` high during cycle N+1 → register file and scoreboard updated at edge N+1 → `hazard` low and combinational read returns new value in cycle N+2.
- Throughput: one write per cycle, back-to-back grants allowed.
- Issue reservation visible on `busy`/`hazard` the cycle after handshake.
- Asynchronous reset mid-operation: in-flight output write dropped, scoreboard cleared immediately; no partial write.

## Configuration
- `WB_BYPASS_EN` defined: `fwd_valid_x`=1 when `reg_write` and `wr_index`==`chk_index_x`≠0; `fwd_data_x`=`write_data`; `hazard_x` suppressed in that case. Removes one stall cycle (hazard clears in N+1).
- Not defined: `fwd_valid_x`=0, `fwd_data_x`=0, hazard as in Operation.

## Structure
- Shared package: WIDTH/REG_BITS defaults, STARVE_LIMIT default, grant-select encoding (NONE, ALU, LD).
- One sub-module natural: `wb_scoreboard` (busy vector, set/clear, hazard/bypass lookup); arbiter and output stage in top.

## Test plan
- Reset with results pending → all outputs 0, `busy`=0; first grant after release writes normally.
- Issue R5, ALU writes R5=0x1234 → `busy[5]` set; `reg_write`=1, `wr_index`=5, `write_data`=0x1234 one cycle after grant; `busy[5]` clear next cycle.
- Both sources valid continuously (R1..R6) → grant pattern LD,LD,LD,ALU repeating; no lost or duplicated writes.
- Result to R0 with value 0xFFFF → ready=1, `reg_write` stays 0, `busy` unchanged.
- ALU result to unreserved R7 → written, `err_unreserved`=1 and stays 1 until reset.
- Issue R3 while busy → `issue_ready`=0; with `WB_BYPASS_EN`, `chk_index_a`=3 during write cycle → `fwd_valid_a`=1, `fwd_data_a`=written value, `hazard_a`=0.
